// File: rtl/ahb_pkg.sv
// Shared AHB encodings, master FSM states and the burst-length helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'b000,
    SIZE_HALF = 3'b001,
    SIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    BURST,
    LAST,
    ERR1,
    ERR2
  } state_e;

  // Undefined-length INCR is issued as a single beat.
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    case (burst[2:1])
      2'b00:   return 5'd1;
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Burst address arithmetic: next beat address (INCR/WRAP) and command legality
// (size, alignment, 1 KB crossing) for a command about to be accepted.
module ahb_burst_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] cur_addr_i,
  input  logic [2:0]        cur_size_i,
  input  logic [2:0]        cur_burst_i,
  output logic [ADDR_W-1:0] next_addr_o,
  input  logic [9:0]        chk_addr_i,
  input  logic [2:0]        chk_size_i,
  input  logic [2:0]        chk_burst_i,
  output logic [4:0]        chk_beats_o,
  output logic              chk_reject_o
);

  localparam logic [ADDR_W-1:0] ONE = 1;

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] cur_beats;
  logic [ADDR_W-1:0] wrap_mask;
  logic [11:0]       chk_bytes;
  logic [11:0]       chk_end;
  logic              bad_size;
  logic              misaligned;
  logic              cross_1k;

  always_comb begin
    step        = ONE << cur_size_i;
    incr_addr   = cur_addr_i + step;
    cur_beats   = {{(ADDR_W-5){1'b0}}, burst_beats(cur_burst_i)};
    wrap_mask   = (cur_beats << cur_size_i) - ONE;
    next_addr_o = incr_addr;
    // Wrapping keeps the upper bits of the aligned block and lets only the low bits roll over.
    if (cur_burst_i inside {BURST_WRAP4, BURST_WRAP8, BURST_WRAP16})
      next_addr_o = (cur_addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
  end

  always_comb begin
    chk_beats_o = burst_beats(chk_burst_i);
    bad_size    = (chk_size_i > SIZE_WORD);
    case (chk_size_i)
      SIZE_HALF: misaligned = chk_addr_i[0];
      SIZE_WORD: misaligned = |chk_addr_i[1:0];
      default:   misaligned = 1'b0;
    endcase
    chk_bytes    = {7'd0, chk_beats_o} << chk_size_i[1:0];
    chk_end      = {2'b00, chk_addr_i} + chk_bytes;
    cross_1k     = chk_burst_i[0] && (chk_end > 12'd1024);
    chk_reject_o = bad_size || misaligned || cross_1k;
  end

endmodule

// File: rtl/ahb_master.sv
// AHB-Lite burst master: accepts one command at a time, issues pipelined
// SINGLE/INCR/WRAP beats, handles wait states and two-cycle ERROR responses.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [1:0]        htrans,
  output logic [1:0]        add_offset,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hresp
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [4:0]        rem_q, rem_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [2:0]        hburst_q;
  logic [DATA_W-1:0] hwdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              cmd_ready_q;

  logic              accept;
  logic              addr_acc;
  logic              data_ok;
  logic              chk_reject;
  logic [4:0]        chk_beats;
  logic [ADDR_W-1:0] next_addr;
  htrans_e           trans;

  ahb_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .cur_addr_i   (haddr_q),
    .cur_size_i   (hsize_q),
    .cur_burst_i  (hburst_q),
    .next_addr_o  (next_addr),
    .chk_addr_i   (cmd_addr[9:0]),
    .chk_size_i   (cmd_size),
    .chk_burst_i  (cmd_burst),
    .chk_beats_o  (chk_beats),
    .chk_reject_o (chk_reject)
  );

  // cmd_ready_q is only ever high in IDLE, so accept implies the FSM is idle.
  assign accept   = cmd_valid && cmd_ready_q;
  assign addr_acc = (state_q == ADDR || state_q == BURST) && hready;
  assign data_ok  = (state_q == BURST || state_q == LAST) && hready && !hresp;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    haddr_d = haddr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (chk_reject) begin
            state_d = ERR2;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ADDR;
            haddr_d = cmd_addr;
            rem_d   = chk_beats;
          end
        end
      end
      ADDR, BURST: begin
        if (hready) begin
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            state_d = LAST;
          end else begin
            state_d = BURST;
            haddr_d = next_addr;
          end
        end else if (hresp && state_q == BURST) begin
          state_d = ERR1;
        end
      end
      LAST: begin
        if (hready) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = hresp;
        end else if (hresp) begin
          state_d = ERR1;
        end
      end
      ERR1: begin
        if (hready) begin
          state_d = ERR2;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      ADDR:    trans = TRANS_NONSEQ;
      BURST:   trans = TRANS_SEQ;
      default: trans = TRANS_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      haddr_q     <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hburst_q    <= '0;
      hwdata_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= (state_d == IDLE);
      rd_valid_q  <= data_ok && !hwrite_q;
      if (accept && !chk_reject) begin
        hwrite_q <= cmd_write;
        hsize_q  <= cmd_size;
        hburst_q <= cmd_burst;
      end
      if (addr_acc && hwrite_q) hwdata_q  <= wr_data;
      if (data_ok && !hwrite_q) rd_data_q <= hrdata;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign wr_ready   = addr_acc && hwrite_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign done       = done_q;
  assign err        = err_q;
  assign htrans     = trans;
  assign hsel       = (trans != TRANS_IDLE);
  assign haddr      = haddr_q;
  assign add_offset = haddr_q[1:0];
  assign hwrite     = hwrite_q;
  assign hsize      = hsize_q;
  assign hburst     = hburst_q;
  assign hwdata     = hwdata_q;

endmodule
